// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: one bus transaction per load/store, upstream frozen until completion.
// Build option: define MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of ignoring the low address bits.
module mem_access_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [2:0]  funct3_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_wstrb_o,
  input  logic        dmem_ready_i,
  input  logic [31:0] dmem_rdata_i,
  output logic [31:0] load_data_o,
  output logic        done_o,
  output logic        stall_o,
  output logic        bus_err_o,
  output logic        misalign_o
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t        state_q;
  logic [CW-1:0] wait_q;
  logic [2:0]    funct3_q;
  logic [1:0]    off_q;
  logic          dmem_req_q;
  logic          dmem_we_q;
  logic [31:0]   dmem_addr_q;
  logic [31:0]   dmem_wdata_q;
  logic [3:0]    dmem_wstrb_q;
  logic [31:0]   load_data_q;
  logic          done_q;
  logic          bus_err_q;
  logic          misalign_q;

  logic          mem_op;
  logic          f3_legal;
  logic          misaligned;
  logic [31:0]   wdata_d;
  logic [3:0]    wstrb_d;
  logic [31:0]   load_d;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;

  // Request decode; a simultaneous read+write is handled as a write.
  always_comb begin
    mem_op = valid_i & (mem_read_i | mem_write_i);
    if (mem_write_i) begin
      f3_legal = (funct3_i < 3'd3);
    end else begin
      case (funct3_i)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_legal = 1'b1;
        default:                                f3_legal = 1'b0;
      endcase
    end
`ifdef MISALIGN_TRAP_EN
    case (funct3_i[1:0])
      2'b01:   misaligned = addr_i[0];
      2'b10:   misaligned = (addr_i[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
`else
    misaligned = 1'b0;
`endif
  end

  // Store lane steering: replicate the datum across all lanes, strobe the addressed ones.
  always_comb begin
    case (funct3_i[1:0])
      2'b00: begin
        wstrb_d = 4'b0001 << addr_i[1:0];
        wdata_d = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        wstrb_d = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{wdata_i[15:0]}};
      end
      default: begin
        wstrb_d = 4'b1111;
        wdata_d = wdata_i;
      end
    endcase
  end

  // Load lane extraction uses the offset and size captured when the access was accepted.
  always_comb begin
    byte_sel = dmem_rdata_i[{off_q, 3'b000} +: 8];
    half_sel = off_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    case (funct3_q)
      3'b000:  load_d = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_d = {24'd0, byte_sel};
      3'b001:  load_d = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_d = {16'd0, half_sel};
      default: load_d = dmem_rdata_i;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wait_q       <= '0;
      funct3_q     <= 3'd0;
      off_q        <= 2'd0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= 32'd0;
      dmem_wdata_q <= 32'd0;
      dmem_wstrb_q <= 4'd0;
      load_data_q  <= 32'd0;
      done_q       <= 1'b0;
      bus_err_q    <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      bus_err_q  <= 1'b0;
      misalign_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (mem_op) begin
            funct3_q <= funct3_i;
            off_q    <= addr_i[1:0];
            wait_q   <= '0;
            if (!f3_legal) begin
              state_q     <= RESP;
              done_q      <= 1'b1;
              bus_err_q   <= 1'b1;
              load_data_q <= 32'd0;
            end else if (misaligned) begin
              state_q     <= RESP;
              done_q      <= 1'b1;
              misalign_q  <= 1'b1;
              load_data_q <= 32'd0;
            end else begin
              state_q      <= ACCESS;
              dmem_req_q   <= 1'b1;
              dmem_we_q    <= mem_write_i;
              dmem_addr_q  <= {addr_i[31:2], 2'b00};
              dmem_wdata_q <= mem_write_i ? wdata_d : 32'd0;
              dmem_wstrb_q <= mem_write_i ? wstrb_d : 4'd0;
            end
          end
        end
        ACCESS: begin
          // A ready on the last permitted cycle still completes the access normally.
          if (dmem_ready_i) begin
            state_q    <= RESP;
            done_q     <= 1'b1;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            if (!dmem_we_q) begin
              load_data_q <= load_d;
            end
          end else if (wait_q == CW'(TIMEOUT - 1)) begin
            state_q     <= RESP;
            done_q      <= 1'b1;
            bus_err_q   <= 1'b1;
            dmem_req_q  <= 1'b0;
            dmem_we_q   <= 1'b0;
            load_data_q <= 32'd0;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Stall is combinational in IDLE so the accepting cycle already holds the upstream registers.
  assign stall_o = rst_n & (((state_q == IDLE) & mem_op) | (state_q == ACCESS));

  assign dmem_req_o   = dmem_req_q;
  assign dmem_we_o    = dmem_we_q;
  assign dmem_addr_o  = dmem_addr_q;
  assign dmem_wdata_o = dmem_wdata_q;
  assign dmem_wstrb_o = dmem_wstrb_q;
  assign load_data_o  = load_data_q;
  assign done_o       = done_q;
  assign bus_err_o    = bus_err_q;
  assign misalign_o   = misalign_q;

endmodule
